// File: rtl/mul_sequencer.sv
// Shift-add multiplier controller for the RV32M MUL path.
// It steps one 32-bit adder up to 32 times to form the low word of a*b.
module mul_sequencer #(
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q;
  logic [31:0] acc_q;
  logic [31:0] mcand_q;
  logic [31:0] mplier_q;
  logic [4:0]  count_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] result_q;

  logic [31:0] add_sum;
  logic [31:0] acc_d;
  logic        early_exit;

  // The adder's carry-out is not needed: the product is taken modulo 2^32.
  always_comb begin
    add_sum    = acc_q + mcand_q;
    acc_d      = mplier_q[0] ? add_sum : acc_q;
    early_exit = SKIP_ZERO && (mplier_q == 32'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      acc_q    <= 32'd0;
      mcand_q  <= 32'd0;
      mplier_q <= 32'd0;
      count_q  <= 5'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 32'd0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q  <= StBusy;
            acc_q    <= 32'd0;
            mcand_q  <= a;
            mplier_q <= b;
            count_q  <= 5'd0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
          end else begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        StBusy: begin
          if (early_exit) begin
            // Remaining multiplier bits are zero, so acc already holds the product.
            state_q  <= StDone;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= acc_q;
          end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            count_q  <= count_q + 5'd1;
            if (count_q == 5'd31) begin
              state_q  <= StDone;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              result_q <= acc_d;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer: runs the SKIP_ZERO=0 and SKIP_ZERO=1 builds side by side
// against a latency/product model, plus directed cases with literal expectations.
module tb_mul_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [1:0]  busy_v;
  logic [1:0]  done_v;
  logic [31:0] res_v [2];

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  mul_sequencer #(.SKIP_ZERO(1'b0)) u_full (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy_v[0]), .done(done_v[0]), .result(res_v[0])
  );

  mul_sequencer #(.SKIP_ZERO(1'b1)) u_skip (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy_v[1]), .done(done_v[1]), .result(res_v[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Cycle in which done appears, counting the start-sampling cycle as 0.
  function automatic int lat(input int i, input logic [31:0] bv);
    int k;
    if (i == 0) return 33;
    if (bv == 32'd0) return 2;
    k = 0;
    for (int j = 0; j < 32; j++) if (bv[j]) k = j;
    return (k + 3 > 33) ? 33 : k + 3;
  endfunction

  // Reference model: busy for lat-1 cycles after an accepted start, then a one-cycle done.
  logic        m_busy [2];
  logic        m_done [2];
  logic [31:0] m_result [2];
  logic [31:0] m_prod [2];
  int          m_left [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_busy[i]   <= 1'b0;
        m_done[i]   <= 1'b0;
        m_result[i] <= 32'd0;
        m_left[i]   <= 0;
      end else if (m_busy[i]) begin
        m_left[i] <= m_left[i] - 1;
        m_busy[i] <= (m_left[i] != 1);
        m_done[i] <= (m_left[i] == 1);
        if (m_left[i] == 1) m_result[i] <= m_prod[i];
      end else begin
        m_done[i] <= 1'b0;
        if (start) begin
          m_busy[i] <= 1'b1;
          m_left[i] <= lat(i, b) - 1;
          m_prod[i] <= a * b;
        end
      end
    end
  end

  bit prev_done [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    if (check_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("d%0d_busy", i), {31'd0, busy_v[i]}, {31'd0, m_busy[i]});
        chk($sformatf("d%0d_done", i), {31'd0, done_v[i]}, {31'd0, m_done[i]});
        chk($sformatf("d%0d_result", i), res_v[i], m_result[i]);
        chk($sformatf("d%0d_busy_and_done", i), {31'd0, busy_v[i] & done_v[i]}, 32'd0);
        chk($sformatf("d%0d_done_twice", i), {31'd0, done_v[i] & prev_done[i]}, 32'd0);
        prev_done[i] <= done_v[i];
      end
    end
  end

  // Starts one operation on both DUTs and checks the cycle of each done and the result.
  task automatic op2(input string nm, input logic [31:0] av, input logic [31:0] bv,
                     input int e0, input int e1, input logic [31:0] er);
    int seen [2];
    seen = '{-1, -1};
    a = av;
    b = bv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    for (int n = 1; n <= 40; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (done_v[i] && seen[i] < 0) begin
          seen[i] = n;
          chk($sformatf("%s_d%0d_res", nm, i), res_v[i], er);
        end
      end
      if (seen[0] >= 0 && seen[1] >= 0) break;
      @(negedge clk);
    end
    chk({nm, "_d0_cycle"}, seen[0], e0);
    chk({nm, "_d1_cycle"}, seen[1], e1);
  endtask

  initial begin
    int n;
    int ndone;
    repeat (2) @(negedge clk);
    chk("reset_busy", {30'd0, busy_v}, 32'd0);
    chk("reset_done", {30'd0, done_v}, 32'd0);
    chk("reset_res0", res_v[0], 32'd0);
    chk("reset_res1", res_v[1], 32'd0);
    reset = 1'b0;
    check_en = 1'b1;
    @(negedge clk);

    op2("mul7x6", 32'd7, 32'd6, 33, 5, 32'd42);
    op2("mulffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 33, 32'h0000_0001);
    op2("mul10000sq", 32'h0001_0000, 32'h0001_0000, 33, 19, 32'h0000_0000);
    op2("mul5x0", 32'd5, 32'd0, 33, 2, 32'd0);
    op2("mul5x1", 32'd5, 32'd1, 33, 3, 32'd5);
    op2("mul3xmsb", 32'd3, 32'h8000_0000, 33, 33, 32'h8000_0000);
    @(negedge clk);

    // A start while busy must not disturb the running operation.
    a = 32'd9; b = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    repeat (9) @(negedge clk);
    a = 32'd2; b = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    chk("ignore_busy", {31'd0, busy_v[0]}, 32'd1);
    n = 11;
    while (!done_v[0] && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("ignore_cycle", n, 33);
    chk("ignore_res0", res_v[0], 32'd81);
    chk("ignore_res1", res_v[1], 32'd4);
    @(negedge clk);

    // Reset in the middle of an operation abandons it.
    a = 32'd12; b = 32'h0000_FFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", {30'd0, busy_v}, 32'd0);
    chk("abort_done", {30'd0, done_v}, 32'd0);
    chk("abort_res0", res_v[0], 32'd0);
    chk("abort_res1", res_v[1], 32'd0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_v != 2'b00) ndone++;
    end
    chk("abort_no_done", ndone, 0);

    // Back-to-back: second start issued during the first done cycle.
    a = 32'd3; b = 32'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    n = 1;
    while (!done_v[0] && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_first_cycle", n, 33);
    chk("b2b_first_res", res_v[0], 32'd12);
    a = 32'd5; b = 32'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    chk("b2b_rebusy", {31'd0, busy_v[0]}, 32'd1);
    chk("b2b_hold", res_v[0], 32'd12);
    n = 1;
    while (!done_v[0] && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_second_cycle", n, 33);
    chk("b2b_second_res0", res_v[0], 32'd30);
    chk("b2b_second_res1", res_v[1], 32'd30);

    // Random traffic, including stray starts and occasional resets.
    repeat (3000) begin
      start = ($urandom % 3 == 0);
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if ($urandom % 8 == 0) b = 32'd0;
      reset = ($urandom % 300 == 0);
      @(negedge clk);
    end
    reset = 1'b0;
    start = 1'b0;
    repeat (40) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
